// File: rtl/i8088_bus_pkg.sv
// Shared types and constants for the 8088 minimum-mode bus initiator.
package i8088_bus_pkg;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} tstate_t;

  localparam logic [7:0] AD_FLOAT_DATA = 8'hFF;

  typedef struct packed {
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic        write;
    logic        io;
  } bus_req_t;

endpackage

// File: rtl/i8088_bus_if.sv
// Request/response port plus 8088 local-bus pins seen by the initiator (master)
// and by whatever drives requests and responds on the bus (slave).
interface i8088_bus_if;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_write;
  logic        req_io;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_err;
  logic [11:0] A19_8;
  logic [7:0]  AD7_0_out;
  logic        AD7_0_enout;
  logic [7:0]  AD7_0_in;
  logic        ALE;
  logic        nRD;
  logic        nWR;
  logic        IO_nM;
  logic        DT_nR;
  logic        nDEN;
  logic        READY;

  modport master (
    input  req_valid, req_addr, req_wdata, req_write, req_io, AD7_0_in, READY,
    output req_ready, resp_valid, resp_rdata, resp_err, A19_8, AD7_0_out,
           AD7_0_enout, ALE, nRD, nWR, IO_nM, DT_nR, nDEN
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_write, req_io, AD7_0_in, READY,
    input  req_ready, resp_valid, resp_rdata, resp_err, A19_8, AD7_0_out,
           AD7_0_enout, ALE, nRD, nWR, IO_nM, DT_nR, nDEN
  );
endinterface

// File: rtl/i8088_bus_initiator.sv
// Minimum-mode 8088 bus initiator: turns valid/ready requests into T1-T4 bus
// cycles with READY-driven wait states and a wait-state timeout.
module i8088_bus_initiator
  import i8088_bus_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input logic         I8088_CLK,
  input logic         CPU_RESET,
  i8088_bus_if.master bus
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  tstate_t           state_q, state_d;
  bus_req_t          req_q, req_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [11:0]       a_hi_q, a_hi_d;
  logic [7:0]        ad_out_q, ad_out_d;
  logic              ad_en_q, ad_en_d;
  logic              ale_q, ale_d;
  logic              nrd_q, nrd_d;
  logic              nwr_q, nwr_d;
  logic              io_q, io_d;
  logic              dtr_q, dtr_d;
  logic              nden_q, nden_d;
  logic              accept;
  logic              timeout;

  always_comb begin
    accept     = bus.req_valid && req_ready_q;
    req_d      = req_q;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout    = 1'b0;
    rdata_d    = rdata_q;

    if (accept) begin
      req_d.addr  = bus.req_addr;
      req_d.wdata = bus.req_wdata;
      req_d.write = bus.req_write;
      req_d.io    = bus.req_io;
    end

    case (state_q)
      IDLE:    if (accept) state_d = T1;
      T1:      state_d = T2;
      T2:      state_d = T3;
      T3, TW: begin
        // Timeout wins over READY once the wait budget is exhausted
        if (wait_cnt_q >= MAX_CNT) begin
          state_d = T4;
          timeout = 1'b1;
        end else if (bus.READY) begin
          state_d = T4;
        end else begin
          state_d    = TW;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      T4:      state_d = accept ? T1 : IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == T1) wait_cnt_d = '0;
    if (state_d == T4 && (state_q == T3 || state_q == TW) && !req_q.write)
      rdata_d = timeout ? AD_FLOAT_DATA : bus.AD7_0_in;

    // Outputs are registered, so they are decoded from the state being entered
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    a_hi_d       = a_hi_q;
    ad_out_d     = ad_out_q;
    ad_en_d      = 1'b0;
    ale_d        = 1'b0;
    nrd_d        = 1'b1;
    nwr_d        = 1'b1;
    io_d         = io_q;
    dtr_d        = dtr_q;
    nden_d       = 1'b1;

    case (state_d)
      IDLE: req_ready_d = 1'b1;
      T1: begin
        ale_d    = 1'b1;
        a_hi_d   = req_d.addr[19:8];
        ad_out_d = req_d.addr[7:0];
        ad_en_d  = 1'b1;
        io_d     = req_d.io;
        dtr_d    = req_d.write;
      end
      T2, T3, TW: begin
        nden_d = 1'b0;
        if (req_d.write) begin
          ad_en_d  = 1'b1;
          ad_out_d = req_d.wdata;
          nwr_d    = 1'b0;
        end else begin
          nrd_d = 1'b0;
        end
      end
      T4: begin
        resp_valid_d = 1'b1;
        resp_err_d   = timeout;
        req_ready_d  = 1'b1;
        ad_en_d      = req_d.write;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I8088_CLK) begin
    if (CPU_RESET) begin
      state_q      <= IDLE;
      req_q        <= '0;
      wait_cnt_q   <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= AD_FLOAT_DATA;
      a_hi_q       <= '0;
      ad_out_q     <= '0;
      ad_en_q      <= 1'b0;
      ale_q        <= 1'b0;
      nrd_q        <= 1'b1;
      nwr_q        <= 1'b1;
      io_q         <= 1'b0;
      dtr_q        <= 1'b0;
      nden_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      wait_cnt_q   <= wait_cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
      a_hi_q       <= a_hi_d;
      ad_out_q     <= ad_out_d;
      ad_en_q      <= ad_en_d;
      ale_q        <= ale_d;
      nrd_q        <= nrd_d;
      nwr_q        <= nwr_d;
      io_q         <= io_d;
      dtr_q        <= dtr_d;
      nden_q       <= nden_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.A19_8       = a_hi_q;
  assign bus.AD7_0_out   = ad_out_q;
  assign bus.AD7_0_enout = ad_en_q;
  assign bus.ALE         = ale_q;
  assign bus.nRD         = nrd_q;
  assign bus.nWR         = nwr_q;
  assign bus.IO_nM       = io_q;
  assign bus.DT_nR       = dtr_q;
  assign bus.nDEN        = nden_q;

endmodule
